jalr_resolve: RTL
=================

# jalr_resolve

Commit-side consumer of the JALR unit's CDB result stream. It captures every mispredicted JALR broadcast (`jalr_cdb_t` with `correct_predict == 0`) in a small tag-indexed table. When the ROB commits a captured tag, it raises a one-cycle pipeline flush and a redirect to the corrected target. It sits between the CDB and the fetch/ROB flush network, beside the ROB commit port.

## Interface
Parameters:
- `DEPTH`, default 4: number of table entries, power of two, 2..16.

Ports:
- `clk`  in  1: core clock.
- `rst`  in  1: reset, asynchronous, active-low (asserted at 0).
- `flush`  in  1: external pipeline flush from other redirect sources.
- `jalr_res`  in  `jalr_cdb_t`: JALR result broadcast (`valid`, `val`, `tag`, `correct_predict`, `pc_next`).
- `commit_valid`  in  1: the ROB head commits this cycle.
- `commit_tag`  in  `tag_t`: ROB tag of the committing entry.
- `redirect_valid`  out  1: one-cycle pulse; fetch must load `redirect_pc`.
- `redirect_pc`  out  32: corrected JALR target.
- `flush_req`  out  1: one-cycle flush request, coincident with `redirect_valid`.
- `full`  out  1: all `DEPTH` entries are valid.
- `overflow`  out  1: sticky error flag; a mispredict was dropped because the table was full.

## Operation
- Each entry holds `valid`, `tag` (`tag_t`) and `pc` (32 bits).
- **Capture.** Condition: `jalr_res.valid && !jalr_res.correct_predict && jalr_res.tag != 0`.
  - The tag and `pc_next` are written into the lowest-index free entry.
  - If any valid entry already holds that tag, the broadcast is dropped; there are no duplicates.
  - Tag 0 means "no tag" and is never captured.
  - Correct predictions are never captured.
- **Full.** When the table is full, a capture is dropped and `overflow` is set. `overflow` clears only on reset.
- **Resolve.** Condition: `commit_valid` and `commit_tag` equals a valid entry's tag (fully associative compare). On the next edge:
  - `redirect_valid` = 1, `flush_req` = 1, `redirect_pc` = that entry's `pc`.
  - All entries are invalidated.
- **External flush.** `flush` = 1 invalidates all entries at the next edge and generates no redirect.
- **Simultaneous events:**
  - `flush` together with a resolve match: `flush` wins and no redirect is issued.
  - A capture in the same cycle as a resolve match or `flush`: the capture is discarded.
  - A capture and a non-matching commit in the same cycle: the capture proceeds.
- No bypass from `jalr_res` to the commit compare in the same cycle. The ROB cannot commit a tag before its CDB write has been registered.
- **Reset** (asynchronous, mid-operation allowed): all entries invalid; `redirect_valid` = 0, `flush_req` = 0, `redirect_pc` = 0, `overflow` = 0, `full` = 0.

## Timing
- Capture latency: 1 cycle. An entry captured at edge N is matchable by a commit presented in cycle N.
- Resolve latency: commit match in cycle N → `redirect_valid`/`flush_req` high during cycle N+1 only. They fall at the N+2 edge unless a new match occurs.
- `redirect_pc` holds its last value when `redirect_valid` is 0.
- `full` is combinational from the valid bits.
- All other outputs are registered.

## Configuration
- Macro: `JALR_RESOLVE_STATS_EN`.
- **Defined:** adds outputs `stat_mispredict` (32 bits) and `stat_correct` (32 bits).
  - Saturating counters, reset to 0; not cleared by `flush`.
  - `stat_mispredict` increments on every committed resolve that issues a redirect.
  - `stat_correct` increments on every `jalr_res.valid && correct_predict`.
- **Undefined:** the ports and counters are absent. Functional behaviour is identical.

## Structure
- `ooo_types`: add `jalr_resolve_entry_t` (`valid`, `tag`, `pc`).
- `jalr_cdb_t` and `tag_t` are reused unchanged.
- One sub-module, `jalr_resolve_alloc`: a lowest-free-index priority encoder with a free/full flag.
- The tag CAM compare stays inline.

## Test plan
- Mispredict tag 5, `pc_next` 0x6000_0100 captured; commit tag 5 three cycles later → next cycle `redirect_valid` = `flush_req` = 1, `redirect_pc` = 0x6000_0100; then 0; table empty.
- `correct_predict` = 1 for tag 3, then commit tag 3 → no redirect; with `JALR_RESOLVE_STATS_EN`, `stat_correct` = 1.
- Capture tags 1..4 (`DEPTH` = 4) → `full` = 1; fifth mispredict (tag 6) → dropped, `overflow` = 1; commit tag 2 → redirect to tag 2's pc.
- Capture tag 7 twice with different pcs → one entry holding the first pc; commit 7 → `redirect_pc` = first pc.
- Capture tag 4, then `flush` asserted in the same cycle as commit tag 4 → no redirect, table empty.
- Assert `rst` = 0 asynchronously while `redirect_valid` = 1 → all outputs 0 immediately; a commit after reset release produces no redirect.

Source files
------------

// File: rtl/ooo_types.sv
// Shared out-of-order core types: ROB tag, JALR CDB bundle
// and the jalr_resolve table entry.
package ooo_types;

    localparam int TAG_W = 6;

    typedef logic [TAG_W-1:0] tag_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] val;
        tag_t        tag;
        logic        correct_predict;
        logic [31:0] pc_next;
    } jalr_cdb_t;

    typedef struct packed {
        logic        valid;
        tag_t        tag;
        logic [31:0] pc;
    } jalr_resolve_entry_t;

endpackage

// File: rtl/jalr_resolve_alloc.sv
// Lowest-free-index priority encoder for the jalr_resolve table.
// Reports whether any slot is free and whether all slots are taken.
module jalr_resolve_alloc #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]         valid_i,
    output logic [$clog2(DEPTH)-1:0] idx_o,
    output logic                     free_o,
    output logic                     full_o
);

    localparam int IW = $clog2(DEPTH);

    always_comb begin
        idx_o  = '0;
        free_o = 1'b0;
        // Scan downward so the lowest free index is the last one written.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_i[i]) begin
                idx_o  = i[IW-1:0];
                free_o = 1'b1;
            end
        end
    end

    assign full_o = &valid_i;

endmodule

// File: rtl/jalr_resolve.sv
// Captures mispredicted JALR broadcasts and redirects fetch on commit.
// Optional macro JALR_RESOLVE_STATS_EN adds saturating stat counters.
module jalr_resolve
    import ooo_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  jalr_cdb_t   jalr_res,
    input  logic        commit_valid,
    input  tag_t        commit_tag,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush_req,
    output logic        full,
    output logic        overflow
`ifdef JALR_RESOLVE_STATS_EN
    ,
    output logic [31:0] stat_mispredict,
    output logic [31:0] stat_correct
`endif
);

    localparam int IW = $clog2(DEPTH);

    jalr_resolve_entry_t ent_q [DEPTH];
    jalr_resolve_entry_t ent_d [DEPTH];

    logic [DEPTH-1:0] vld;
    logic [IW-1:0]    alloc_idx;
    logic             alloc_free;

    logic        capture;
    logic        dup;
    logic        hit;
    logic [31:0] hit_pc;
    logic        redirect;
    logic        clear;
    logic        wr;
    logic        drop;

    logic        redirect_valid_q;
    logic        flush_req_q;
    logic [31:0] redirect_pc_q;
    logic [31:0] redirect_pc_d;
    logic        overflow_q;
    logic        overflow_d;

    logic unused_val;
    assign unused_val = ^jalr_res.val;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            vld[i] = ent_q[i].valid;
        end
    end

    jalr_resolve_alloc #(
        .DEPTH (DEPTH)
    ) u_alloc (
        .valid_i (vld),
        .idx_o   (alloc_idx),
        .free_o  (alloc_free),
        .full_o  (full)
    );

    assign capture = jalr_res.valid
                   && !jalr_res.correct_predict
                   && (jalr_res.tag != '0);

    always_comb begin
        dup    = 1'b0;
        hit    = 1'b0;
        hit_pc = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && ent_q[i].tag == jalr_res.tag) begin
                dup = 1'b1;
            end
            // Tags are unique in the table, so OR-ing the pcs is safe.
            if (commit_valid && vld[i]
                && ent_q[i].tag == commit_tag) begin
                hit    = 1'b1;
                hit_pc = hit_pc | ent_q[i].pc;
            end
        end
    end

    assign redirect = hit && !flush;
    assign clear    = flush || hit;
    assign wr       = capture && !dup && !clear && alloc_free;
    assign drop     = capture && !dup && !clear && !alloc_free;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (clear) begin
                ent_d[i].valid = 1'b0;
            end else if (wr && alloc_idx == i[IW-1:0]) begin
                ent_d[i].valid = 1'b1;
                ent_d[i].tag   = jalr_res.tag;
                ent_d[i].pc    = jalr_res.pc_next;
            end
        end
    end

    assign redirect_pc_d = redirect ? hit_pc : redirect_pc_q;
    assign overflow_d    = overflow_q || drop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            redirect_valid_q <= 1'b0;
            flush_req_q      <= 1'b0;
            redirect_pc_q    <= '0;
            overflow_q       <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            redirect_valid_q <= redirect;
            flush_req_q      <= redirect;
            redirect_pc_q    <= redirect_pc_d;
            overflow_q       <= overflow_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign flush_req      = flush_req_q;
    assign redirect_pc    = redirect_pc_q;
    assign overflow       = overflow_q;

`ifdef JALR_RESOLVE_STATS_EN
    logic [31:0] stat_mis_q;
    logic [31:0] stat_cor_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_mis_q <= '0;
            stat_cor_q <= '0;
        end else begin
            if (redirect && stat_mis_q != '1) begin
                stat_mis_q <= stat_mis_q + 32'd1;
            end
            if (jalr_res.valid && jalr_res.correct_predict
                && stat_cor_q != '1) begin
                stat_cor_q <= stat_cor_q + 32'd1;
            end
        end
    end

    assign stat_mispredict = stat_mis_q;
    assign stat_correct    = stat_cor_q;
`endif

endmodule
